// File: rtl/com_cmd_parser.sv
// com_cmd_parser: parses ASCII "S<a><h><l>" write commands from uart_rx into the DATA_IN register bank.
// Define CMD_ACK_EN to build the one-entry ack byte output ('K' on commit, '?' on error).
module com_cmd_parser #(
  parameter int NREG        = 4,
  parameter int TIMEOUT_CYC = 3125
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            RX_VALID,
  input  logic [7:0]      RX_DATA,
  output logic [7:0]      DATA_IN0,
  output logic [7:0]      DATA_IN1,
  output logic [7:0]      DATA_IN2,
  output logic [7:0]      DATA_IN3,
  output logic [NREG-1:0] WR_STROBE,
  output logic            ERR,
  output logic            ACK_VALID,
  output logic [7:0]      ACK_DATA,
  input  logic            ACK_READY
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] ADDR_END = 8'(8'h30 + NREG);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_HI, S_LO, S_TERM} state_t;

  state_t          r_state, w_next;
  logic [TW-1:0]   r_timer;
  logic [3:0]      r_addr, r_hi, r_lo;
  logic [7:0]      r_data [NREG];
  logic [NREG-1:0] r_wr, w_wr;
  logic            r_err;
  logic            w_commit, w_err, w_tmo, w_ld_addr, w_ld_hi, w_ld_lo;

  function automatic logic is_start(input logic [7:0] b);
    return (b == 8'h53) || (b == 8'h73);
  endfunction

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  // Letters 'A'..'F' / 'a'..'f' both carry 1..6 in the low nibble.
  function automatic logic [3:0] hex_nib(input logic [7:0] b);
    if (b <= 8'h39) return b[3:0];
    return b[3:0] + 4'd9;
  endfunction

  always_comb begin
    w_next    = r_state;
    w_commit  = 1'b0;
    w_err     = 1'b0;
    w_ld_addr = 1'b0;
    w_ld_hi   = 1'b0;
    w_ld_lo   = 1'b0;
    w_tmo     = (r_state != S_IDLE) && (r_timer == TMAX);
    if (RX_VALID) begin
      case (r_state)
        S_IDLE: if (is_start(RX_DATA)) w_next = S_ADDR;
        S_ADDR: begin
          if (RX_DATA >= 8'h30 && RX_DATA < ADDR_END) begin
            w_ld_addr = 1'b1;
            w_next    = S_HI;
          end else begin
            w_err  = 1'b1;
            w_next = S_IDLE;
          end
        end
        S_HI: begin
          if (is_hex(RX_DATA)) begin
            w_ld_hi = 1'b1;
            w_next  = S_LO;
          end else begin
            w_err  = 1'b1;
            w_next = S_IDLE;
          end
        end
        S_LO: begin
          if (is_hex(RX_DATA)) begin
            w_ld_lo = 1'b1;
            w_next  = S_TERM;
          end else begin
            w_err  = 1'b1;
            w_next = S_IDLE;
          end
        end
        S_TERM: begin
          if (RX_DATA == 8'h0A || RX_DATA == 8'h0D) begin
            w_commit = 1'b1;
            w_next   = S_IDLE;
          end else if (is_start(RX_DATA)) begin
            w_commit = 1'b1;
            w_next   = S_ADDR;
          end else begin
            w_err  = 1'b1;
            w_next = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end else if (w_tmo) begin
      // An idle line ends the frame: a complete command commits, a partial one is an error.
      w_next = S_IDLE;
      if (r_state == S_TERM) w_commit = 1'b1;
      else                   w_err    = 1'b1;
    end
  end

  always_comb begin
    w_wr = '0;
    for (int k = 0; k < NREG; k++) w_wr[k] = w_commit && (r_addr == 4'(k));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_addr  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_wr    <= '0;
      r_err   <= 1'b0;
      for (int k = 0; k < NREG; k++) r_data[k] <= 8'h00;
    end else begin
      r_state <= w_next;
      if (RX_VALID || r_state == S_IDLE) r_timer <= '0;
      else if (r_timer != TMAX)          r_timer <= r_timer + 1'b1;
      if (w_ld_addr) r_addr <= RX_DATA[3:0];
      if (w_ld_hi)   r_hi   <= hex_nib(RX_DATA);
      if (w_ld_lo)   r_lo   <= hex_nib(RX_DATA);
      r_wr  <= w_wr;
      r_err <= w_err;
      for (int k = 0; k < NREG; k++)
        if (w_wr[k]) r_data[k] <= {r_hi, r_lo};
    end
  end

  assign WR_STROBE = r_wr;
  assign ERR       = r_err;

  // Registers beyond the four dedicated ports have no output pins.
  always_comb begin
    DATA_IN0 = r_data[0];
    DATA_IN1 = 8'h00;
    DATA_IN2 = 8'h00;
    DATA_IN3 = 8'h00;
    if (NREG > 1) DATA_IN1 = r_data[1];
    if (NREG > 2) DATA_IN2 = r_data[2];
    if (NREG > 3) DATA_IN3 = r_data[3];
  end

`ifdef CMD_ACK_EN
  logic       r_ack_valid;
  logic [7:0] r_ack_data;

  // A new ack overwrites a pending one; the handshake only clears when nothing new arrives.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ack_valid <= 1'b0;
      r_ack_data  <= 8'h00;
    end else if (w_commit) begin
      r_ack_valid <= 1'b1;
      r_ack_data  <= 8'h4B;
    end else if (w_err) begin
      r_ack_valid <= 1'b1;
      r_ack_data  <= 8'h3F;
    end else if (r_ack_valid && ACK_READY) begin
      r_ack_valid <= 1'b0;
    end
  end

  assign ACK_VALID = r_ack_valid;
  assign ACK_DATA  = r_ack_data;
`else
  logic w_unused_ack_ready;
  assign w_unused_ack_ready = ACK_READY;
  assign ACK_VALID = 1'b0;
  assign ACK_DATA  = 8'h00;
`endif

endmodule

// File: tb/tb_com_cmd_parser.sv
// Bench for com_cmd_parser: directed command frames plus a randomized byte stream against a
// buffer-based command model. Define CMD_ACK_EN to also exercise the ack output.
module tb_com_cmd_parser;
  localparam int NREG = 4;
  localparam int TMO  = 3125;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       RX_VALID;
  logic [7:0] RX_DATA;
  logic [7:0] DATA_IN0, DATA_IN1, DATA_IN2, DATA_IN3;
  logic [3:0] WR_STROBE;
  logic       ERR;
  logic       ACK_VALID;
  logic [7:0] ACK_DATA;
  logic       ACK_READY;

  com_cmd_parser #(.NREG(NREG), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST_N(RST_N), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
    .DATA_IN0(DATA_IN0), .DATA_IN1(DATA_IN1), .DATA_IN2(DATA_IN2), .DATA_IN3(DATA_IN3),
    .WR_STROBE(WR_STROBE), .ERR(ERR), .ACK_VALID(ACK_VALID), .ACK_DATA(ACK_DATA),
    .ACK_READY(ACK_READY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: the characters of the command collected so far, plus expected outputs.
  byte unsigned pend[$];
  logic [7:0]   m_data [4];
  logic [3:0]   m_wr;
  logic         m_err;
  logic         m_ackv;
  logic [7:0]   m_ackd;

  function automatic int hexval(input int c);
    if (c >= 48 && c <= 57) return c - 48;
    if (c >= 65 && c <= 70) return c - 65 + 10;
    return c - 97 + 10;
  endfunction

  function automatic bit is_hexc(input int c);
    return (c >= 48 && c <= 57) || (c >= 65 && c <= 70) || (c >= 97 && c <= 102);
  endfunction

  function automatic logic [45:0] obs_vec();
    return {WR_STROBE, ERR, DATA_IN3, DATA_IN2, DATA_IN1, DATA_IN0, ACK_VALID, ACK_DATA};
  endfunction

  function automatic logic [45:0] exp_vec();
    return {m_wr, m_err, m_data[3], m_data[2], m_data[1], m_data[0], m_ackv, m_ackd};
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int k = 0; k < 4; k++) m_data[k] = 8'h00;
    m_wr = 4'b0; m_err = 1'b0; m_ackv = 1'b0; m_ackd = 8'h00;
  endtask

  task automatic model_ack(input logic [7:0] c);
`ifdef CMD_ACK_EN
    m_ackv = 1'b1;
    m_ackd = c;
`else
    if (c == 8'h00) m_ackv = 1'b0;
`endif
  endtask

  task automatic model_commit();
    int a, v;
    a = int'(pend[1]) - 48;
    v = hexval(pend[2]) * 16 + hexval(pend[3]);
    m_data[a] = v[7:0];
    m_wr[a]   = 1'b1;
    model_ack(8'h4B);
  endtask

  task automatic model_fail();
    pend.delete();
    m_err = 1'b1;
    model_ack(8'h3F);
  endtask

  task automatic model_byte(input logic [7:0] b);
    int n;
    bit st;
    n  = pend.size();
    st = (b == 8'h53) || (b == 8'h73);
    m_wr = 4'b0; m_err = 1'b0;
    if (n == 0) begin
      if (st) pend.push_back(b);
    end else if (n == 1) begin
      if (b >= 8'h30 && int'(b) < 48 + NREG) pend.push_back(b);
      else model_fail();
    end else if (n < 4) begin
      if (is_hexc(b)) pend.push_back(b);
      else model_fail();
    end else if (b == 8'h0A || b == 8'h0D) begin
      model_commit();
      pend.delete();
    end else if (st) begin
      model_commit();
      pend.delete();
      pend.push_back(b);
    end else begin
      model_fail();
    end
  endtask

  task automatic model_timeout();
    m_wr = 4'b0; m_err = 1'b0;
    if (pend.size() == 4) begin
      model_commit();
      pend.delete();
    end else if (pend.size() != 0) begin
      model_fail();
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
    model_byte(b);
  endtask

  task automatic idle(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(posedge CLK); #1;
      if (WR_STROBE != 4'b0 || ERR) pulses++;
    end
    m_wr = 4'b0; m_err = 1'b0;
  endtask

  task automatic wait_event(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge CLK); #1;
      if (WR_STROBE != 4'b0 || ERR) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00; ACK_READY = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (obs_vec() !== 46'b0) begin
      failures++;
      $display("FAIL reset_values: got %h required 0", obs_vec());
    end
    RST_N = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (obs_vec() !== 46'b0) begin
      failures++;
      $display("FAIL reset_release: got %h required 0", obs_vec());
    end
  endtask

  task automatic test_write();
    string s;
    int p;
    s = "S0E6\n";
    for (int i = 0; i < s.len(); i++) begin
      drive_byte(s[i]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL write byte%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      if (i == s.len() - 1) begin
        checks++;
        if (DATA_IN0 !== 8'hE6 || WR_STROBE !== 4'b0001 || ERR !== 1'b0) begin
          failures++;
          $display("FAIL write_commit: got data=%h wr=%b err=%b required E6 0001 0",
                   DATA_IN0, WR_STROBE, ERR);
        end
      end
      idle(1042, p);
      checks++;
      if (p !== 0) begin
        failures++;
        $display("FAIL write_gap byte%0d: got %0d pulses required 0", i, p);
      end
    end
  endtask

  task automatic test_timeout();
    string s;
    int p, cyc;
    s = "S2D4";
    for (int i = 0; i < s.len(); i++) begin
      drive_byte(s[i]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL tmo byte%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      if (i != s.len() - 1) idle(10, p);
    end
    wait_event(TMO + 20, cyc);
    model_timeout();
    checks++;
    if (cyc < TMO - 1 || cyc > TMO + 1) begin
      failures++;
      $display("FAIL tmo_latency: got %0d cycles required %0d", cyc, TMO);
    end
    checks++;
    if (DATA_IN2 !== 8'hD4 || WR_STROBE !== 4'b0100 || DATA_IN0 !== 8'hE6) begin
      failures++;
      $display("FAIL tmo_commit: got d2=%h wr=%b d0=%h required D4 0100 E6",
               DATA_IN2, WR_STROBE, DATA_IN0);
    end
    idle(1, p);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL tmo_after: got %h required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_errors();
    string frames [3];
    int p, cyc;
    frames[0] = "S5A1\n";
    frames[1] = "S1G0\n";
    frames[2] = "S3a";
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < frames[f].len(); i++) begin
        drive_byte(frames[f][i]);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL err f%0d byte%0d: got %h required %h", f, i, obs_vec(), exp_vec());
        end
        if (i != frames[f].len() - 1 || f != 2) idle(20, p);
      end
    end
    wait_event(TMO + 20, cyc);
    model_timeout();
    checks++;
    if (cyc < 0 || ERR !== 1'b1 || WR_STROBE !== 4'b0) begin
      failures++;
      $display("FAIL err_timeout: got cyc=%0d err=%b wr=%b required err=1 wr=0", cyc, ERR, WR_STROBE);
    end
    checks++;
    if ({DATA_IN3, DATA_IN1} !== 16'h0000) begin
      failures++;
      $display("FAIL err_nowrite: got %h required 0000", {DATA_IN3, DATA_IN1});
    end
    idle(1, p);
  endtask

  task automatic test_back_to_back();
    string s;
    int p;
    s = "s1ffS30c\015";
    for (int i = 0; i < s.len(); i++) begin
      drive_byte(s[i]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL b2b byte%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      if (i == 4) begin
        checks++;
        if (DATA_IN1 !== 8'hFF || WR_STROBE !== 4'b0010) begin
          failures++;
          $display("FAIL b2b_first: got %h %b required FF 0010", DATA_IN1, WR_STROBE);
        end
      end
    end
    idle(2, p);
    checks++;
    if (DATA_IN3 !== 8'h0C || DATA_IN1 !== 8'hFF || p !== 0) begin
      failures++;
      $display("FAIL b2b_final: got d3=%h d1=%h pulses=%0d required 0C FF 0", DATA_IN3, DATA_IN1, p);
    end
  endtask

  task automatic test_reset_midframe();
    string s;
    int p;
    s = "S2A";
    for (int i = 0; i < s.len(); i++) begin
      drive_byte(s[i]);
      idle(5, p);
    end
    RST_N = 1'b0;
    #2;
    model_reset();
    checks++;
    if (obs_vec() !== 46'b0) begin
      failures++;
      $display("FAIL midreset: got %h required 0", obs_vec());
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    s = "S27F\n";
    for (int i = 0; i < s.len(); i++) begin
      drive_byte(s[i]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL postreset byte%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
      idle(3, p);
    end
    checks++;
    if (DATA_IN2 !== 8'h7F) begin
      failures++;
      $display("FAIL postreset_data: got %h required 7F", DATA_IN2);
    end
  endtask

  task automatic test_random();
    byte unsigned stream[$];
    string hexs, junk;
    int p, cyc, tmos, errs;
    hexs = "0123456789ABCDEFabcdef";
    junk = "Ss0123456789AFafGz\n\015?";
    while (stream.size() < 250) begin
      if ($urandom_range(0, 9) < 6) begin
        int t;
        stream.push_back($urandom_range(0, 1) ? 8'h53 : 8'h73);
        stream.push_back(8'(48 + $urandom_range(0, NREG - 1)));
        stream.push_back(hexs[$urandom_range(0, hexs.len() - 1)]);
        stream.push_back(hexs[$urandom_range(0, hexs.len() - 1)]);
        t = $urandom_range(0, 2);
        if (t == 0) stream.push_back(8'h0A);
        else if (t == 1) stream.push_back(8'h0D);
      end else begin
        stream.push_back(junk[$urandom_range(0, junk.len() - 1)]);
      end
    end
`ifdef CMD_ACK_EN
    ACK_READY = 1'b0;
`else
    ACK_READY = 1'b1;
`endif
    tmos = 0; errs = 0;
    foreach (stream[i]) begin
      drive_byte(stream[i]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errs++;
        failures++;
        if (errs < 10) $display("FAIL rand byte%0d (%h): got %h required %h", i, stream[i], obs_vec(), exp_vec());
      end
      if (pend.size() != 0 && tmos < 3 && $urandom_range(0, 59) == 0) begin
        tmos++;
        wait_event(TMO + 20, cyc);
        model_timeout();
        checks++;
        if (cyc < 0 || obs_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL rand_timeout: got cyc=%0d %h required %h", cyc, obs_vec(), exp_vec());
        end
        idle(1, p);
      end else begin
        idle($urandom_range(0, 25), p);
        checks++;
        if (p !== 0) begin
          failures++;
          $display("FAIL rand_gap byte%0d: got %0d pulses required 0", i, p);
        end
      end
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL rand_final: got %h required %h", obs_vec(), exp_vec());
    end
    if (pend.size() != 0) begin
      wait_event(TMO + 20, cyc);
      model_timeout();
      checks++;
      if (cyc < 0 || obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL rand_end_timeout: got cyc=%0d %h required %h", cyc, obs_vec(), exp_vec());
      end
      idle(1, p);
    end
    ACK_READY = 1'b0;
  endtask

`ifdef CMD_ACK_EN
  task automatic test_ack();
    string s;
    int p;
    ACK_READY = 1'b1;
    @(posedge CLK); #1;
    ACK_READY = 1'b0;
    m_ackv = 1'b0;
    checks++;
    if (ACK_VALID !== 1'b0) begin
      failures++;
      $display("FAIL ack_drain: got %b required 0", ACK_VALID);
    end
    s = "S0E6\n";
    for (int i = 0; i < s.len(); i++) begin
      drive_byte(s[i]);
      idle(5, p);
    end
    checks++;
    if (ACK_VALID !== 1'b1 || ACK_DATA !== 8'h4B) begin
      failures++;
      $display("FAIL ack_commit: got %b %h required 1 4B", ACK_VALID, ACK_DATA);
    end
    s = "S9";
    for (int i = 0; i < s.len(); i++) begin
      drive_byte(s[i]);
      idle(5, p);
    end
    checks++;
    if (ACK_VALID !== 1'b1 || ACK_DATA !== 8'h3F) begin
      failures++;
      $display("FAIL ack_err: got %b %h required 1 3F", ACK_VALID, ACK_DATA);
    end
    ACK_READY = 1'b1;
    @(posedge CLK); #1;
    ACK_READY = 1'b0;
    m_ackv = 1'b0;
    checks++;
    if (ACK_VALID !== 1'b0) begin
      failures++;
      $display("FAIL ack_handshake: got %b required 0", ACK_VALID);
    end
    idle(3, p);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL ack_idle: got %h required %h", obs_vec(), exp_vec());
    end
  endtask
`else
  task automatic test_ack_off();
    string s;
    int p;
    s = "S1A5\n";
    for (int i = 0; i < s.len(); i++) begin
      ACK_READY = $urandom_range(0, 1);
      drive_byte(s[i]);
      checks++;
      if (ACK_VALID !== 1'b0 || ACK_DATA !== 8'h00) begin
        failures++;
        $display("FAIL ack_off byte%0d: got %b %h required 0 00", i, ACK_VALID, ACK_DATA);
      end
      idle(2, p);
    end
    ACK_READY = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_timeout();
    test_errors();
    test_back_to_back();
    test_reset_midframe();
`ifdef CMD_ACK_EN
    test_ack();
`else
    test_ack_off();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
